// File: rtl/route_sequencer_pkg.sv
// Shared definitions for the route sequencer: drive codes, FSM states,
// route table constants and the table lookup helpers.
package route_sequencer_pkg;

  localparam int UNIT_W = 12;
  localparam int STEP_W = 2;
  localparam int POS_W  = 2;

  // Drive codes understood by the motor/PWM stage
  typedef enum logic [2:0] {
    DRIVE_Stop     = 3'd0,
    DRIVE_Straight = 3'd1,
    DRIVE_Left     = 3'd2,
    DRIVE_Right    = 3'd3,
    DRIVE_Reverse  = 3'd4
  } drive_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_ARRIVED = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  // Segment lengths in duration units; 0 terminates a route
  localparam logic [UNIT_W-1:0] TURN_UNITS     = 12'd400;
  localparam logic [UNIT_W-1:0] APPROACH_UNITS = 12'd1200;
  localparam logic [UNIT_W-1:0] DIRECT_UNITS   = 12'd1500;
  localparam logic [UNIT_W-1:0] END_UNITS      = 12'd0;

  // Drive code for a given position and step
  function automatic drive_e route_code(input logic [POS_W-1:0] pos,
                                        input logic [STEP_W-1:0] step);
    drive_e code;
    code = DRIVE_Stop;
    case ({pos, step})
      {2'd1, 2'd0}: code = DRIVE_Left;
      {2'd1, 2'd1}: code = DRIVE_Straight;
      {2'd2, 2'd0}: code = DRIVE_Straight;
      {2'd3, 2'd0}: code = DRIVE_Right;
      {2'd3, 2'd1}: code = DRIVE_Straight;
      default:      code = DRIVE_Stop;
    endcase
    return code;
  endfunction

  // Segment length for a given position and step; END_UNITS past the last segment
  function automatic logic [UNIT_W-1:0] route_units(input logic [POS_W-1:0] pos,
                                                    input logic [STEP_W-1:0] step);
    logic [UNIT_W-1:0] units;
    units = END_UNITS;
    case ({pos, step})
      {2'd1, 2'd0}: units = TURN_UNITS;
      {2'd1, 2'd1}: units = APPROACH_UNITS;
      {2'd2, 2'd0}: units = DIRECT_UNITS;
      {2'd3, 2'd0}: units = TURN_UNITS;
      {2'd3, 2'd1}: units = APPROACH_UNITS;
      default:      units = END_UNITS;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/route_sequencer_segment_timer.sv
// Segment timer: tick prescaler feeding a unit counter. Flags the final
// cycle of a segment of `units` duration units while enabled.
module segment_timer
  import route_sequencer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [UNIT_W-1:0] units,
  output logic              seg_done
);

  localparam int TICK_W = $clog2(TICKS_PER_UNIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

  logic [TICK_W-1:0] tick_q;
  logic [UNIT_W-1:0] unit_q;
  logic              tick_wrap;
  logic              unit_last;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign unit_last = (unit_q == (units - 12'd1));
  assign seg_done  = enable && tick_wrap && unit_last;

  // Count ticks while enabled; both counters wrap to zero at segment end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_q <= '0;
      unit_q <= '0;
    end else if (enable) begin
      if (tick_wrap) begin
        tick_q <= '0;
        unit_q <= unit_last ? '0 : unit_q + 12'd1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_sequencer.sv
// Route sequencer: plays the timed drive-segment table for the latched
// target position, pausing on obstacle, and reports arrival or fault.
module route_sequencer
  import route_sequencer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [POS_W-1:0]  target_pos,
  input  logic              obstacle,
  input  logic              ack,
  output logic [2:0]        route_request,
  output logic              pwm_go,
  output logic              busy,
  output logic              arrived,
  output logic              fault,
  output logic [STEP_W-1:0] step
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  drive_e              rr_q, rr_d;
  logic                pwm_q, pwm_d;
  logic                tmr_clear;
  logic                tmr_en;
  logic                seg_done;
  drive_e              cur_code;
  logic [UNIT_W-1:0]   cur_units;
  logic [UNIT_W-1:0]   next_units;

  assign cur_code   = route_code(pos_q, step_q);
  assign cur_units  = route_units(pos_q, step_q);
  assign next_units = route_units(pos_q, step_q + 2'd1);

  segment_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .units    (cur_units),
    .seg_done (seg_done)
  );

  // State, step, latched position and registered drive outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      pos_q   <= '0;
      rr_q    <= DRIVE_Stop;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      rr_q    <= rr_d;
      pwm_q   <= pwm_d;
    end
  end

  // Next-state and drive decode. A cycle only counts as motion when the
  // sequencer is active and obstacle is low; that same condition drives the
  // timer and the motor outputs, so the leaving cycle of a PAUSE is already
  // a motion cycle and every obstacle cycle is exactly one lost cycle.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pos_d     = pos_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    rr_d      = DRIVE_Stop;
    pwm_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (target_pos != 2'd0) begin
            pos_d     = target_pos;
            step_d    = '0;
            tmr_clear = 1'b1;
            state_d   = obstacle ? ST_PAUSE : ST_RUN;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (obstacle) begin
          state_d = ST_PAUSE;
        end else begin
          tmr_en  = 1'b1;
          rr_d    = cur_code;
          pwm_d   = 1'b1;
          state_d = ST_RUN;
          if (seg_done) begin
            step_d = step_q + 2'd1;
            if (next_units == END_UNITS) begin
              state_d = ST_ARRIVED;
            end
          end
        end
      end
      ST_ARRIVED, ST_FAULT: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign route_request = rr_q;
  assign pwm_go        = pwm_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign arrived       = (state_q == ST_ARRIVED);
  assign fault         = (state_q == ST_FAULT);
  assign step          = step_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Directed testbench for route_sequencer with TICKS_PER_UNIT=2.
module tb_route_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] target_pos;
  logic       obstacle;
  logic       ack;
  logic [2:0] route_request;
  logic       pwm_go;
  logic       busy;
  logic       arrived;
  logic       fault;
  logic [1:0] step;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] C_STOP     = 3'd0;
  localparam logic [2:0] C_STRAIGHT = 3'd1;
  localparam logic [2:0] C_LEFT     = 3'd2;
  localparam logic [2:0] C_RIGHT    = 3'd3;

  route_sequencer #(.TICKS_PER_UNIT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .target_pos    (target_pos),
    .obstacle      (obstacle),
    .ack           (ack),
    .route_request (route_request),
    .pwm_go        (pwm_go),
    .busy          (busy),
    .arrived       (arrived),
    .fault         (fault),
    .step          (step)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] pos);
    start      = 1'b1;
    target_pos = pos;
    cycle();
    start      = 1'b0;
  endtask

  // Count consecutive motor-on cycles carrying the given code
  task automatic count_run(input logic [2:0] code, input int limit, output int n);
    n = 0;
    while (pwm_go === 1'b1 && route_request === code && n < limit) begin
      n++;
      cycle();
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target_pos = 2'd0; obstacle = 1'b0; ack = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({route_request, pwm_go, busy, arrived, fault, step} !== 9'd0) begin
      $display("FAIL reset_outputs: got %b expected 000000000",
               {route_request, pwm_go, busy, arrived, fault, step});
      n_fail++;
    end
  endtask

  task automatic test_pos2();
    int n;
    pulse_start(2'd2);
    n_checks++;
    if (busy !== 1'b1 || pwm_go !== 1'b0) begin
      $display("FAIL pos2_latency: busy=%0b pwm_go=%0b expected busy=1 pwm_go=0", busy, pwm_go);
      n_fail++;
    end
    cycle();
    count_run(C_STRAIGHT, 5000, n);
    n_checks++;
    if (n !== 3000) begin
      $display("FAIL pos2_straight_len: got %0d expected 3000", n);
      n_fail++;
    end
    n_checks++;
    if (arrived !== 1'b1 || route_request !== C_STOP || pwm_go !== 1'b0) begin
      $display("FAIL pos2_arrived: arrived=%0b rr=%0d pwm=%0b expected 1 0 0",
               arrived, route_request, pwm_go);
      n_fail++;
    end
    // ack and start in the same cycle: start must be ignored
    ack = 1'b1; start = 1'b1; target_pos = 2'd2;
    cycle();
    ack = 1'b0; start = 1'b0;
    n_checks++;
    if (arrived !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL pos2_ack_idle: arrived=%0b busy=%0b expected 0 0", arrived, busy);
      n_fail++;
    end
    cycle();
    n_checks++;
    if (busy !== 1'b0 || pwm_go !== 1'b0) begin
      $display("FAIL ack_start_ignored: busy=%0b pwm=%0b expected 0 0", busy, pwm_go);
      n_fail++;
    end
  endtask

  task automatic test_pos1();
    int n;
    pulse_start(2'd1);
    cycle();
    n_checks++;
    if (step !== 2'd0 || route_request !== C_LEFT) begin
      $display("FAIL pos1_first: step=%0d rr=%0d expected 0 2", step, route_request);
      n_fail++;
    end
    count_run(C_LEFT, 5000, n);
    n_checks++;
    if (n !== 800) begin
      $display("FAIL pos1_left_len: got %0d expected 800", n);
      n_fail++;
    end
    n_checks++;
    if (step !== 2'd1 || route_request !== C_STRAIGHT || pwm_go !== 1'b1) begin
      $display("FAIL pos1_seamless: step=%0d rr=%0d pwm=%0b expected 1 1 1",
               step, route_request, pwm_go);
      n_fail++;
    end
    count_run(C_STRAIGHT, 5000, n);
    n_checks++;
    if (n !== 2400 || arrived !== 1'b1) begin
      $display("FAIL pos1_straight_len: got %0d arrived=%0b expected 2400 arrived=1", n, arrived);
      n_fail++;
    end
    pulse_ack();
  endtask

  task automatic test_pause_pos3();
    int total, run, stopc, bad_step;
    total = 0; run = 0; stopc = 0; bad_step = 0;
    pulse_start(2'd3);
    cycle();
    while (!(arrived === 1'b1 && pwm_go === 1'b0) && total < 5000) begin
      if (pwm_go === 1'b1) begin
        run++;
      end else begin
        stopc++;
        if (step !== 2'd0 || route_request !== C_STOP) bad_step++;
      end
      obstacle = (total >= 499 && total < 549);
      total++;
      cycle();
    end
    obstacle = 1'b0;
    n_checks++;
    if (run !== 3200) begin
      $display("FAIL pause_run_cycles: got %0d expected 3200", run);
      n_fail++;
    end
    n_checks++;
    if (stopc !== 50 || bad_step !== 0) begin
      $display("FAIL pause_stop_cycles: got %0d (bad %0d) expected 50 (bad 0)", stopc, bad_step);
      n_fail++;
    end
    n_checks++;
    if (total !== 3250) begin
      $display("FAIL pause_total: got %0d expected 3250", total);
      n_fail++;
    end
    pulse_ack();
  endtask

  task automatic test_fault();
    pulse_start(2'd0);
    n_checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || route_request !== C_STOP || pwm_go !== 1'b0) begin
      $display("FAIL fault_entry: fault=%0b busy=%0b rr=%0d pwm=%0b expected 1 0 0 0",
               fault, busy, route_request, pwm_go);
      n_fail++;
    end
    pulse_start(2'd2);
    cycle();
    n_checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || pwm_go !== 1'b0) begin
      $display("FAIL fault_start_ignored: fault=%0b busy=%0b pwm=%0b expected 1 0 0",
               fault, busy, pwm_go);
      n_fail++;
    end
    pulse_ack();
    n_checks++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL fault_ack: fault=%0b busy=%0b expected 0 0", fault, busy);
      n_fail++;
    end
  endtask

  task automatic test_final_cycle_obstacle();
    int n;
    pulse_start(2'd1);
    cycle();
    n = 0;
    while (pwm_go === 1'b1 && route_request === C_LEFT && n < 798) begin
      n++;
      cycle();
    end
    n_checks++;
    if (n !== 798 || route_request !== C_LEFT) begin
      $display("FAIL final_pre: got %0d rr=%0d expected 798 rr=2", n, route_request);
      n_fail++;
    end
    obstacle = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (pwm_go !== 1'b0 || step !== 2'd0 || busy !== 1'b1) begin
      $display("FAIL final_paused: pwm=%0b step=%0d busy=%0b expected 0 0 1", pwm_go, step, busy);
      n_fail++;
    end
    obstacle = 1'b0;
    cycle();
    n_checks++;
    if (route_request !== C_LEFT || pwm_go !== 1'b1) begin
      $display("FAIL final_resume_left: rr=%0d pwm=%0b expected 2 1", route_request, pwm_go);
      n_fail++;
    end
    cycle();
    n_checks++;
    if (route_request !== C_STRAIGHT || step !== 2'd1) begin
      $display("FAIL final_then_straight: rr=%0d step=%0d expected 1 1", route_request, step);
      n_fail++;
    end
    count_run(C_STRAIGHT, 5000, n);
    n_checks++;
    if (n !== 2400 || arrived !== 1'b1) begin
      $display("FAIL final_straight_len: got %0d arrived=%0b expected 2400 1", n, arrived);
      n_fail++;
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_start(2'd2);
    cycle();
    for (int i = 0; i < 999; i++) begin
      ack        = (i == 400);
      start      = (i == 400);
      target_pos = 2'd0;
      cycle();
    end
    ack = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || fault !== 1'b0 || pwm_go !== 1'b1 || route_request !== C_STRAIGHT) begin
      $display("FAIL run_ignores_ack_start: busy=%0b fault=%0b pwm=%0b rr=%0d expected 1 0 1 1",
               busy, fault, pwm_go, route_request);
      n_fail++;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({route_request, pwm_go, busy, arrived, fault, step} !== 9'd0) begin
      $display("FAIL reset_mid_run: got %b expected 000000000",
               {route_request, pwm_go, busy, arrived, fault, step});
      n_fail++;
    end
    pulse_start(2'd3);
    cycle();
    count_run(C_RIGHT, 5000, n);
    n_checks++;
    if (n !== 800 || step !== 2'd1) begin
      $display("FAIL rerun_right_len: got %0d step=%0d expected 800 1", n, step);
      n_fail++;
    end
    count_run(C_STRAIGHT, 5000, n);
    n_checks++;
    if (n !== 2400 || arrived !== 1'b1) begin
      $display("FAIL rerun_straight_len: got %0d arrived=%0b expected 2400 1", n, arrived);
      n_fail++;
    end
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_pos2();
    test_pos1();
    test_pause_pos3();
    test_fault();
    test_final_cycle_obstacle();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
